// File: rtl/usb_pkg.sv
// Shared definitions for the full-speed USB receive path.
// Contents: rx_packet status codes, PID nibble values, packet FSM states,
// the decoded SYNC pattern, the default oversampling ratio, and a helper
// that maps a PID low nibble to its status code.
package usb_pkg;

    localparam int unsigned ClksPerBitDefault = 8;

    // SYNC (KJKJKJKK) NRZI-decodes to seven zeros then a one, LSB first.
    localparam logic [7:0] SyncPattern = 8'h80;

    localparam logic [3:0] PidOut   = 4'h1;
    localparam logic [3:0] PidIn    = 4'h9;
    localparam logic [3:0] PidData0 = 4'h3;
    localparam logic [3:0] PidData1 = 4'hB;
    localparam logic [3:0] PidAck   = 4'h2;
    localparam logic [3:0] PidNak   = 4'hA;

    typedef enum logic [2:0] {
        PktNone  = 3'd0,
        PktOut   = 3'd1,
        PktIn    = 3'd2,
        PktData0 = 3'd3,
        PktData1 = 3'd4,
        PktAck   = 3'd5,
        PktNak   = 3'd6,
        PktError = 3'd7
    } rx_code_e;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StBody,
        StEop,
        StErr
    } rx_state_e;

    // Unsupported PID values map to PktError.
    function automatic rx_code_e pid_to_code(input logic [3:0] nib);
        case (nib)
            PidOut:   return PktOut;
            PidIn:    return PktIn;
            PidData0: return PktData0;
            PidData1: return PktData1;
            PidAck:   return PktAck;
            PidNak:   return PktNak;
            default:  return PktError;
        endcase
    endfunction

endpackage

// File: rtl/usb_rx_bit_decoder.sv
// Line-level front end of the USB receiver.
// Synchronizes D+/D-, recovers bit timing with a phase counter that realigns
// on every D+ edge, samples at the bit centre, NRZI-decodes and removes
// stuff bits.
// Ports:
//   clk, n_rst          system clock, synchronous active-high reset
//   dplus_in, dminus_in raw asynchronous line pair
//   in_packet           high while SYNC/PID/BODY are being received
//   bit_valid           strobe: a non-SE0, non-stuff symbol was sampled
//   rx_bit              decoded bit value (valid with bit_valid)
//   se0                 strobe: an SE0 symbol was sampled
//   stuff_err           strobe: a stuff slot decoded to 1
//   line_j              strobe: the sampled symbol was J
module usb_rx_bit_decoder
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic clk,
    input  logic n_rst,
    input  logic dplus_in,
    input  logic dminus_in,
    input  logic in_packet,
    output logic bit_valid,
    output logic rx_bit,
    output logic se0,
    output logic stuff_err,
    output logic line_j
);

    localparam int unsigned PhaseW = $clog2(CLKS_PER_BIT);
    localparam logic [PhaseW-1:0] PhaseMax    = PhaseW'(CLKS_PER_BIT - 1);
    localparam logic [PhaseW-1:0] SamplePhase = PhaseW'(3);

    logic              dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q, dp_prev_q;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              prev_j_q, prev_j_d;
    logic [2:0]        ones_q, ones_d;

    logic sample, sym_se0, sym_j, decoded, stuff_slot;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            // Synchronizers start at idle J so reset release is not seen as an edge.
            dp_meta_q <= 1'b1;
            dp_sync_q <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_sync_q <= 1'b0;
            dp_prev_q <= 1'b1;
            phase_q   <= '0;
            prev_j_q  <= 1'b1;
            ones_q    <= '0;
        end else begin
            dp_meta_q <= dplus_in;
            dp_sync_q <= dp_meta_q;
            dm_meta_q <= dminus_in;
            dm_sync_q <= dm_meta_q;
            dp_prev_q <= dp_sync_q;
            phase_q   <= phase_d;
            prev_j_q  <= prev_j_d;
            ones_q    <= ones_d;
        end
    end

    always_comb begin
        sample     = (phase_q == SamplePhase);
        sym_se0    = !dp_sync_q && !dm_sync_q;
        sym_j      = dp_sync_q && !dm_sync_q;
        decoded    = (sym_j == prev_j_q);
        stuff_slot = in_packet && (ones_q == 3'd6);

        if ((dp_sync_q != dp_prev_q) || (phase_q == PhaseMax)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end

        prev_j_d  = prev_j_q;
        ones_d    = ones_q;
        bit_valid = 1'b0;
        rx_bit    = decoded;
        se0       = 1'b0;
        stuff_err = 1'b0;
        line_j    = 1'b0;

        if (sample) begin
            if (sym_se0) begin
                // Next packet's NRZI reference is J.
                se0      = 1'b1;
                prev_j_d = 1'b1;
                ones_d   = '0;
            end else begin
                prev_j_d = sym_j;
                line_j   = sym_j;
                if (stuff_slot) begin
                    stuff_err = decoded;
                    ones_d    = '0;
                end else begin
                    bit_valid = 1'b1;
                    if (!in_packet || !decoded) begin
                        ones_d = '0;
                    end else begin
                        ones_d = ones_q + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/usb_rx_unit.sv
// Full-speed USB packet receiver.
// Tracks SYNC/PID/BODY/EOP, reports each packet's type on rx_packet and
// streams DATA0/DATA1 payload bytes with the trailing CRC16 stripped by a
// two-byte delay line.
// Ports:
//   clk, n_rst          system clock (CLKS_PER_BIT x bit rate), sync active-high reset
//   dplus_in, dminus_in raw asynchronous line pair
//   rx_packet           packet status code (usb_pkg::rx_code_e)
//   store_rx_packet     one-cycle strobe, rx_packet_data valid
//   rx_packet_data      payload byte, LSB received first
module usb_rx_unit
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    output logic [2:0] rx_packet,
    output logic       store_rx_packet,
    output logic [7:0] rx_packet_data
);

    logic bit_valid, rx_bit, se0, stuff_err, line_j, in_packet;

    rx_state_e  state_q, state_d;
    rx_code_e   pid_q, pid_d, rx_packet_q, rx_packet_d;
    logic [7:0] shift_q, shift_d, dly0_q, dly0_d, dly1_q, dly1_d, data_q, data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] j_cnt_q, j_cnt_d;
    logic [1:0] dly_cnt_q, dly_cnt_d;
    logic       se0_seen_q, se0_seen_d, err_se0_q, err_se0_d, store_q, store_d;

    logic [7:0] new_byte;
    logic       byte_done, go_err, err_on_se0;

    assign in_packet = (state_q == StSync) || (state_q == StPid) || (state_q == StBody);
    assign new_byte  = {rx_bit, shift_q[7:1]};
    assign byte_done = bit_valid && (bit_cnt_q == 3'd7);

    usb_rx_bit_decoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_decoder (
        .clk      (clk),
        .n_rst    (n_rst),
        .dplus_in (dplus_in),
        .dminus_in(dminus_in),
        .in_packet(in_packet),
        .bit_valid(bit_valid),
        .rx_bit   (rx_bit),
        .se0      (se0),
        .stuff_err(stuff_err),
        .line_j   (line_j)
    );

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q     <= StIdle;
            pid_q       <= PktNone;
            rx_packet_q <= PktNone;
            shift_q     <= '0;
            dly0_q      <= '0;
            dly1_q      <= '0;
            data_q      <= '0;
            bit_cnt_q   <= '0;
            j_cnt_q     <= '0;
            dly_cnt_q   <= '0;
            se0_seen_q  <= 1'b0;
            err_se0_q   <= 1'b0;
            store_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            rx_packet_q <= rx_packet_d;
            shift_q     <= shift_d;
            dly0_q      <= dly0_d;
            dly1_q      <= dly1_d;
            data_q      <= data_d;
            bit_cnt_q   <= bit_cnt_d;
            j_cnt_q     <= j_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            se0_seen_q  <= se0_seen_d;
            err_se0_q   <= err_se0_d;
            store_q     <= store_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        rx_packet_d = rx_packet_q;
        shift_d     = shift_q;
        dly0_d      = dly0_q;
        dly1_d      = dly1_q;
        data_d      = data_q;
        bit_cnt_d   = bit_cnt_q;
        j_cnt_d     = j_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        se0_seen_d  = se0_seen_q;
        err_se0_d   = err_se0_q;
        store_d     = 1'b0;
        go_err      = 1'b0;
        err_on_se0  = 1'b0;

        if (bit_valid) begin
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            StIdle: begin
                // First K is also the first SYNC bit.
                if (bit_valid && !line_j) begin
                    state_d     = StSync;
                    rx_packet_d = PktNone;
                    bit_cnt_d   = 3'd1;
                    dly_cnt_d   = '0;
                    se0_seen_d  = 1'b0;
                end else begin
                    bit_cnt_d = '0;
                end
            end
            StSync: begin
                if (se0) begin
                    go_err     = 1'b1;
                    err_on_se0 = 1'b1;
                end else if (stuff_err) begin
                    go_err = 1'b1;
                end else if (byte_done) begin
                    if (new_byte == SyncPattern) state_d = StPid;
                    else go_err = 1'b1;
                end
            end
            StPid: begin
                if (se0) begin
                    go_err     = 1'b1;
                    err_on_se0 = 1'b1;
                end else if (stuff_err) begin
                    go_err = 1'b1;
                end else if (byte_done) begin
                    if ((new_byte[3:0] == ~new_byte[7:4]) &&
                        (pid_to_code(new_byte[3:0]) != PktError)) begin
                        pid_d   = pid_to_code(new_byte[3:0]);
                        state_d = StBody;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            StBody: begin
                if (se0) begin
                    if (bit_cnt_q != 3'd0) begin
                        go_err     = 1'b1;
                        err_on_se0 = 1'b1;
                    end else if (se0_seen_q) begin
                        state_d = StEop;
                    end else begin
                        se0_seen_d = 1'b1;
                    end
                end else if (stuff_err || (bit_valid && se0_seen_q)) begin
                    go_err = 1'b1;
                end else if (byte_done) begin
                    if (pid_q == PktAck || pid_q == PktNak) begin
                        go_err = 1'b1;
                    end else if (pid_q == PktData0 || pid_q == PktData1) begin
                        // Hold two bytes back so the CRC16 never leaves the block.
                        dly1_d = dly0_q;
                        dly0_d = new_byte;
                        if (dly_cnt_q == 2'd2) begin
                            store_d = 1'b1;
                            data_d  = dly1_q;
                        end else begin
                            dly_cnt_d = dly_cnt_q + 2'd1;
                        end
                    end
                end
            end
            StEop: begin
                if (line_j) begin
                    state_d     = StIdle;
                    rx_packet_d = pid_q;
                end else if (bit_valid) begin
                    go_err = 1'b1;
                end
            end
            StErr: begin
                // Leave after SE0 then J, or after 16 idle J bit times.
                if (se0) begin
                    err_se0_d = 1'b1;
                    j_cnt_d   = '0;
                end else if (line_j) begin
                    if (err_se0_q || (j_cnt_q == 4'd15)) state_d = StIdle;
                    else j_cnt_d = j_cnt_q + 4'd1;
                end else if (bit_valid) begin
                    j_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_err) begin
            state_d     = StErr;
            rx_packet_d = PktError;
            j_cnt_d     = '0;
            err_se0_d   = err_on_se0;
        end
    end

    assign rx_packet       = rx_packet_q;
    assign store_rx_packet = store_q;
    assign rx_packet_data  = data_q;

endmodule

// File: tb/tb_usb_rx_unit.sv
module tb_usb_rx_unit;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       dplus_in;
    logic       dminus_in;
    logic [2:0] rx_packet;
    logic       store_rx_packet;
    logic [7:0] rx_packet_data;

    always #5 tb_clk = ~tb_clk;

    usb_rx_unit #(
        .CLKS_PER_BIT(8)
    ) dut (
        .clk            (tb_clk),
        .n_rst          (n_rst),
        .dplus_in       (dplus_in),
        .dminus_in      (dminus_in),
        .rx_packet      (rx_packet),
        .store_rx_packet(store_rx_packet),
        .rx_packet_data (rx_packet_data)
    );

    // Expected output events: strobe carrying a byte, or rx_packet change.
    typedef struct {
        bit         is_strobe;
        logic [7:0] value;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         passes = 0;
    logic [2:0] exp_last = 3'd0;
    bit         mon_en = 1'b0;

    bit lvl_j = 1'b1;
    int ones = 0;
    bit corrupt_stuff = 1'b0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic exp_code(input logic [2:0] c);
        ev_t e;
        if (c != exp_last) begin
            e.is_strobe = 1'b0;
            e.value     = {5'd0, c};
            exp_q.push_back(e);
        end
        exp_last = c;
    endtask

    task automatic exp_strobe(input logic [7:0] v);
        ev_t e;
        e.is_strobe = 1'b1;
        e.value     = v;
        exp_q.push_back(e);
    endtask

    task automatic drive_sym(input logic dp, input logic dm);
        dplus_in  = dp;
        dminus_in = dm;
        repeat (8) @(negedge tb_clk);
    endtask

    task automatic send_level();
        if (lvl_j) drive_sym(1'b1, 1'b0);
        else drive_sym(1'b0, 1'b1);
    endtask

    task automatic send_raw(input bit b);
        if (!b) lvl_j = !lvl_j;
        send_level();
    endtask

    task automatic send_data_bit(input bit b);
        send_raw(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            send_raw(corrupt_stuff);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    task automatic send_sync();
        lvl_j = 1'b1;
        ones  = 0;
        send_byte(8'h80);
    endtask

    task automatic send_eop();
        drive_sym(1'b0, 1'b0);
        drive_sym(1'b0, 1'b0);
        lvl_j = 1'b1;
        repeat (4) send_level();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        logic [2:0] last_code;
        ev_t        e;
        wait (mon_en);
        last_code = rx_packet;
        forever begin
            @(negedge tb_clk);
            if (store_rx_packet) begin
                if (exp_q.size() == 0) check("unexpected_strobe", {1'b1, rx_packet_data}, 9'h000);
                else begin
                    e = exp_q.pop_front();
                    check("strobe_event", {1'b1, rx_packet_data}, {e.is_strobe, e.value});
                end
            end
            if (rx_packet != last_code) begin
                if (exp_q.size() == 0) check("unexpected_code", {6'd0, rx_packet}, {6'd0, last_code});
                else begin
                    e = exp_q.pop_front();
                    check("code_event", {6'd0, rx_packet}, {e.is_strobe, e.value});
                end
                last_code = rx_packet;
            end
        end
    end

    initial begin
        n_rst     = 1'b1;
        dplus_in  = 1'b1;
        dminus_in = 1'b0;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        check("reset_rx_packet", {6'd0, rx_packet}, 9'd0);
        check("reset_store", {8'd0, store_rx_packet}, 9'd0);
        check("reset_data", {1'b0, rx_packet_data}, 9'd0);
        n_rst  = 1'b0;
        mon_en = 1'b1;
        repeat (4) send_level();

        // ACK handshake
        exp_code(3'd0);
        exp_code(3'd5);
        send_sync();
        send_byte(8'hD2);
        send_eop();

        // DATA0 with two payload bytes and CRC
        exp_code(3'd0);
        exp_strobe(8'hA5);
        exp_strobe(8'h3C);
        exp_code(3'd3);
        send_sync();
        send_byte(8'hC3);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h12);
        send_byte(8'h34);
        send_eop();

        // Stuffed payload
        exp_code(3'd0);
        exp_strobe(8'hFF);
        exp_strobe(8'hFF);
        exp_code(3'd3);
        send_sync();
        send_byte(8'hC3);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        send_eop();

        // Stuff bit forced to 1
        exp_code(3'd0);
        exp_code(3'd7);
        corrupt_stuff = 1'b1;
        send_sync();
        send_byte(8'hC3);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        send_eop();
        corrupt_stuff = 1'b0;

        // Bad PID then a valid NAK
        exp_code(3'd0);
        exp_code(3'd7);
        send_sync();
        send_byte(8'hC4);
        send_eop();
        exp_code(3'd0);
        exp_code(3'd6);
        send_sync();
        send_byte(8'h5A);
        send_eop();

        // DATA1 ending after 12 payload bits
        exp_code(3'd0);
        exp_code(3'd7);
        send_sync();
        send_byte(8'h4B);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_data_bit(i >= 2);
        send_eop();

        // Reset in the middle of a DATA0 packet
        exp_code(3'd0);
        send_sync();
        send_byte(8'hC3);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_data_bit(1'b0);
        n_rst     = 1'b1;
        dplus_in  = 1'b1;
        dminus_in = 1'b0;
        lvl_j     = 1'b1;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        check("midreset_rx_packet", {6'd0, rx_packet}, 9'd0);
        check("midreset_store", {8'd0, store_rx_packet}, 9'd0);
        check("midreset_data", {1'b0, rx_packet_data}, 9'd0);
        n_rst = 1'b0;
        repeat (6) send_level();

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge tb_clk);
        check("events_left", 9'(exp_q.size()), 9'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
